// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline datapath and hazard_ctrl.
// The datapath side (master) presents the ID-stage decode fields and the
// EX-stage redirect flags; the hazard unit (slave) returns the pipeline
// control (stall/flush), operand-forwarding selects and event counters.
interface hazard_ctrl_if #(
   parameter int RW = 5,   // register-index width
   parameter int CW = 16   // performance counter width
);
   // ID-stage instruction description
   logic          id_valid;
   logic [RW-1:0] id_ra;
   logic [RW-1:0] id_rb;
   logic          id_ra_use;
   logic          id_rb_use;
   logic [RW-1:0] id_rd;
   logic          id_we;
   logic          id_is_ld;

   // EX-stage control-flow redirect
   logic          ex_brc;
   logic          ex_jump;

   // Pipeline control returned by the hazard unit
   logic          stall;
   logic          flush;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   modport master (
      output id_valid, id_ra, id_rb, id_ra_use, id_rb_use,
             id_rd, id_we, id_is_ld, ex_brc, ex_jump,
      input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_ra, id_rb, id_ra_use, id_rb_use,
             id_rd, id_we, id_is_ld, ex_brc, ex_jump,
      output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- data/control hazard unit for a 5-stage in-order pipeline.
//
// The unit mirrors the EX, MEM and WB stages with small shadow slots
// ({valid, rd, we, is_ld}) and compares them against the source registers
// of the instruction sitting in ID.
//
// Build option: HAZARD_FWD_EN
//   defined   : operands are forwarded from EX/MEM (fwd=01) or MEM/WB
//               (fwd=10); only a load immediately ahead of its consumer
//               costs one stall cycle.
//   undefined : no forwarding (fwd always 00); a consumer stalls while its
//               producer sits in the EX or MEM slot (up to two cycles).
//               The register file writes through in WB, so a WB producer
//               never costs a stall.
//
// Branch/jump redirects from EX (ex_brc/ex_jump) flush IF/ID and ID/EX and
// take priority over any stall. Stall and flush cycles are counted in
// saturating counters.
module hazard_ctrl #(
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic         CLK,
   input  logic         RSTn,
   hazard_ctrl_if.slave bus
);

   // ------------------------------------------------------------------
   // Shadow pipeline slots and FSM state
   // ------------------------------------------------------------------
   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rd;
      logic          we;
      logic          is_ld;
   } slot_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   slot_t         ex_reg;
   slot_t         mem_reg;
   slot_t         wb_reg;
   state_t        state_reg;
   logic [CW-1:0] stall_cnt_reg;
   logic [CW-1:0] flush_cnt_reg;

   // ------------------------------------------------------------------
   // Source-hit detection
   // ------------------------------------------------------------------
   // A slot hits a source when it holds a real register-writing
   // instruction whose destination is that source and the ID instruction
   // actually reads it.
   function automatic logic slot_hits(input slot_t         s,
                                      input logic [RW-1:0] src,
                                      input logic          src_used);
      return s.valid && s.we && (s.rd == src) && src_used;
   endfunction

   logic ex_hit_a;
   logic ex_hit_b;
   logic mem_hit_a;
   logic mem_hit_b;
   logic wb_hit_a;
   logic wb_hit_b;

   assign ex_hit_a  = slot_hits(ex_reg,  bus.id_ra, bus.id_ra_use);
   assign ex_hit_b  = slot_hits(ex_reg,  bus.id_rb, bus.id_rb_use);
   assign mem_hit_a = slot_hits(mem_reg, bus.id_ra, bus.id_ra_use);
   assign mem_hit_b = slot_hits(mem_reg, bus.id_rb, bus.id_rb_use);
   assign wb_hit_a  = slot_hits(wb_reg,  bus.id_ra, bus.id_ra_use);
   assign wb_hit_b  = slot_hits(wb_reg,  bus.id_rb, bus.id_rb_use);

   // ------------------------------------------------------------------
   // Hazard decision
   // ------------------------------------------------------------------
   logic       flush_c;
   logic       hazard_c;
   logic       stall_c;
   logic [1:0] fwd_a_c;
   logic [1:0] fwd_b_c;

   // Redirects are ignored while reset is held so the pipeline comes out
   // of reset in a quiet state.
   assign flush_c = RSTn && (bus.ex_brc || bus.ex_jump);

`ifdef HAZARD_FWD_EN
   // Only a load still in EX cannot be forwarded in time: its data appears
   // at the end of MEM, so the consumer waits one cycle and then picks the
   // value up from EX/MEM.
   assign hazard_c = bus.id_valid && ex_reg.is_ld && (ex_hit_a || ex_hit_b);

   // Operand select: the youngest producer (MEM) wins over the older (WB).
   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
      if (RSTn && bus.id_valid) begin
         if (mem_hit_a)
            fwd_a_c = 2'b01;
         else if (wb_hit_a)
            fwd_a_c = 2'b10;

         if (mem_hit_b)
            fwd_b_c = 2'b01;
         else if (wb_hit_b)
            fwd_b_c = 2'b10;
      end
   end
`else
   // Without bypass paths any producer still in EX or MEM must retire to
   // WB (write-through register file) before the consumer may read.
   assign hazard_c = bus.id_valid &&
                     (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);

   // Operands always come from the register file.
   always_comb begin
      fwd_a_c = 2'b00;
      fwd_b_c = 2'b00;
   end
`endif

   // A flush squashes the stalled instruction anyway, so it wins.
   assign stall_c = RSTn && hazard_c && !flush_c;

   assign bus.stall     = stall_c;
   assign bus.flush     = flush_c;
   assign bus.fwd_a     = fwd_a_c;
   assign bus.fwd_b     = fwd_b_c;
   assign bus.stall_cnt = stall_cnt_reg;
   assign bus.flush_cnt = flush_cnt_reg;

   // ------------------------------------------------------------------
   // Shadow pipeline advance and pipeline-mode FSM
   // ------------------------------------------------------------------
   // Slots shift every cycle; EX takes the ID instruction unless it is
   // being held (stall) or squashed (flush), in which case a bubble enters.
   // The FSM records whether the previous cycle stalled or flushed; a
   // repeated flush simply keeps it in FLUSH.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         ex_reg    <= '0;
         mem_reg   <= '0;
         wb_reg    <= '0;
         state_reg <= ST_RUN;
      end else begin
         wb_reg  <= mem_reg;
         mem_reg <= ex_reg;

         if (stall_c || flush_c) begin
            ex_reg <= '0;
         end else begin
            ex_reg.valid <= bus.id_valid;
            ex_reg.rd    <= bus.id_rd;
            ex_reg.we    <= bus.id_we;
            ex_reg.is_ld <= bus.id_is_ld;
         end

         if (flush_c)
            state_reg <= ST_FLUSH;
         else if (stall_c)
            state_reg <= ST_STALL;
         else
            state_reg <= ST_RUN;
      end
   end

   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   // Count stall and flush cycles; each counter parks at all-ones.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall_c && (stall_cnt_reg != {CW{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         if (flush_c && (flush_cnt_reg != {CW{1'b1}}))
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
   end

   // Fields that only one build flavour consumes, plus the pipeline-mode
   // state that is kept for debug visibility rather than to drive outputs.
   logic unused_sink;
   assign unused_sink = ^{ex_reg.is_ld, mem_reg.is_ld, wb_reg.is_ld,
                          wb_hit_a, wb_hit_b, state_reg};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Table of hand-derived vectors, reset/saturation sequences, and random
// traffic checked against a queue-based model of the instructions in flight.
module tb_hazard_ctrl;
   localparam int RW = 5;
   localparam int CW = 16;

   logic CLK;
   logic RSTn;

   hazard_ctrl_if #(.RW(RW), .CW(CW)) bus ();

   hazard_ctrl #(.RW(RW), .CW(CW)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   typedef struct {
      logic          rstn;
      logic          id_valid;
      logic [RW-1:0] ra;
      logic [RW-1:0] rb;
      logic          ra_use;
      logic          rb_use;
      logic [RW-1:0] rd;
      logic          we;
      logic          ld;
      logic          brc;
      logic          jump;
   } stim_t;

   typedef struct {
      stim_t      in;
      logic       stall;
      logic       flush;
      logic [1:0] fa;
      logic [1:0] fb;
      int         scnt;
      int         fcnt;
   } vec_t;

   function automatic stim_t st(input bit rstn, input bit v, input int ra,
                                input int rb, input bit ua, input bit ub,
                                input int rd, input bit we, input bit ld,
                                input bit brc, input bit jmp);
      stim_t s;
      s.rstn = rstn;  s.id_valid = v;
      s.ra = RW'(ra); s.rb = RW'(rb); s.ra_use = ua; s.rb_use = ub;
      s.rd = RW'(rd); s.we = we; s.ld = ld; s.brc = brc; s.jump = jmp;
      return s;
   endfunction

   function automatic vec_t vc(input stim_t s, input bit stall, input bit flush,
                               input int fa, input int fb, input int scnt,
                               input int fcnt);
      vec_t v;
      v.in = s; v.stall = stall; v.flush = flush;
      v.fa = 2'(fa); v.fb = 2'(fb); v.scnt = scnt; v.fcnt = fcnt;
      return v;
   endfunction

   task automatic drive(input stim_t s);
      RSTn          = s.rstn;
      bus.id_valid  = s.id_valid;
      bus.id_ra     = s.ra;
      bus.id_rb     = s.rb;
      bus.id_ra_use = s.ra_use;
      bus.id_rb_use = s.rb_use;
      bus.id_rd     = s.rd;
      bus.id_we     = s.we;
      bus.id_is_ld  = s.ld;
      bus.ex_brc    = s.brc;
      bus.ex_jump   = s.jump;
   endtask

   // One reset cycle with idle inputs; returns at the following negedge.
   task automatic do_reset();
      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // ------------------------------------------------------------------
   // Reference model: queue of instructions in flight, [0]=EX [1]=MEM [2]=WB
   // ------------------------------------------------------------------
   typedef struct {
      bit valid;
      int rd;
      bit we;
      bit ld;
   } instr_t;

   instr_t in_flight[$];
   int     m_scnt;
   int     m_fcnt;

   function automatic bit produces(input instr_t p, input int src, input bit used);
      return p.valid && p.we && (p.rd == src) && used;
   endfunction

   task automatic model_clear();
      instr_t bub;
      bub = '{valid: 0, rd: 0, we: 0, ld: 0};
      in_flight.delete();
      repeat (3) in_flight.push_back(bub);
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   task automatic run_random(input int n);
      stim_t  s;
      instr_t ex_i, mem_i, wb_i, issued;
      bit     e_flush, e_stall, hz;
      int     e_fa, e_fb, ra, rb;
      for (int i = 0; i < n; i++) begin
         s = st((i == 0) ? 0 : ($urandom_range(0, 99) != 0),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 9) < 3,
                $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
         drive(s);
         ex_i = in_flight[0]; mem_i = in_flight[1]; wb_i = in_flight[2];
         ra = int'(s.ra); rb = int'(s.rb);

         e_flush = s.rstn && (s.brc || s.jump);
         e_fa = 0;
         e_fb = 0;
`ifdef HAZARD_FWD_EN
         // Only a load one step ahead is too late to bypass.
         hz = s.id_valid && ex_i.ld &&
              (produces(ex_i, ra, s.ra_use) || produces(ex_i, rb, s.rb_use));
         if (s.rstn && s.id_valid) begin
            e_fa = produces(mem_i, ra, s.ra_use) ? 1 :
                   produces(wb_i,  ra, s.ra_use) ? 2 : 0;
            e_fb = produces(mem_i, rb, s.rb_use) ? 1 :
                   produces(wb_i,  rb, s.rb_use) ? 2 : 0;
         end
`else
         // Anything not yet in WB must be waited for.
         hz = s.id_valid &&
              (produces(ex_i, ra, s.ra_use)  || produces(ex_i, rb, s.rb_use) ||
               produces(mem_i, ra, s.ra_use) || produces(mem_i, rb, s.rb_use));
         if (produces(wb_i, ra, s.ra_use)) e_fa = 0;
`endif
         e_stall = s.rstn && hz && !e_flush;

         #2;
         chk($sformatf("rnd%0d.stall", i), 32'(bus.stall), 32'(e_stall));
         chk($sformatf("rnd%0d.flush", i), 32'(bus.flush), 32'(e_flush));
         chk($sformatf("rnd%0d.fwd_a", i), 32'(bus.fwd_a), 32'(e_fa));
         chk($sformatf("rnd%0d.fwd_b", i), 32'(bus.fwd_b), 32'(e_fb));
         if (i != 0) begin
            chk($sformatf("rnd%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(m_scnt));
            chk($sformatf("rnd%0d.flush_cnt", i), 32'(bus.flush_cnt), 32'(m_fcnt));
         end

         @(posedge CLK);
         if (!s.rstn) begin
            model_clear();
         end else begin
            issued = '{valid: 0, rd: 0, we: 0, ld: 0};
            if (!(e_stall || e_flush))
               issued = '{valid: s.id_valid, rd: int'(s.rd), we: s.we, ld: s.ld};
            in_flight.push_front(issued);
            void'(in_flight.pop_back());
            if (e_stall) m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
            if (e_flush) m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
         end
         @(negedge CLK);
      end
   endtask

   // ------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------
   vec_t vt[$];

   initial begin
      // Vector table: ID contents per cycle, expected outputs sampled
      // before that cycle's edge. Counters show totals from earlier edges.
`ifdef HAZARD_FWD_EN
      vt.push_back(vc(st(0,1,3,3,1,1,4,1,0,1,0), 0,0,0,0, 0,0)); // reset masks brc
      vt.push_back(vc(st(1,1,1,2,1,1,3,1,1,0,0), 0,0,0,0, 0,0)); // LD r3
      vt.push_back(vc(st(1,1,3,5,1,1,4,1,0,0,0), 1,0,0,0, 0,0)); // ADD r4,r3,r5 load-use
      vt.push_back(vc(st(1,1,3,5,1,1,4,1,0,0,0), 0,0,1,0, 1,0)); // held ADD: fwd_a=01
      vt.push_back(vc(st(1,1,7,4,1,1,6,1,0,0,0), 0,0,0,0, 1,0)); // SUB r6,r7,r4 back-to-back
      vt.push_back(vc(st(1,1,4,6,1,1,8,1,0,0,0), 0,0,1,0, 1,0)); // r4 in MEM
      vt.push_back(vc(st(1,1,4,6,1,1,9,1,0,0,0), 0,0,2,1, 1,0)); // r4 in WB, r6 in MEM
      vt.push_back(vc(st(1,0,8,6,1,1,0,0,0,0,0), 0,0,0,0, 1,0)); // invalid ID: fwd 00
      vt.push_back(vc(st(1,1,0,0,0,0,5,1,1,0,0), 0,0,0,0, 1,0)); // LD r5
      vt.push_back(vc(st(1,1,5,0,1,0,6,1,0,1,0), 0,1,0,0, 1,0)); // brc over load-use
      vt.push_back(vc(st(1,1,5,0,1,0,6,1,0,0,1), 0,1,1,0, 1,1)); // jump; LD r5 in MEM
      vt.push_back(vc(st(1,0,0,0,0,0,0,0,0,0,1), 0,1,0,0, 1,2)); // consecutive flush
      vt.push_back(vc(st(1,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 1,3)); // idle
`else
      vt.push_back(vc(st(0,1,3,3,1,1,4,1,0,1,0), 0,0,0,0, 0,0)); // reset masks brc
      vt.push_back(vc(st(1,1,1,2,1,1,3,1,0,0,0), 0,0,0,0, 0,0)); // ADD r3
      vt.push_back(vc(st(1,1,3,3,1,1,4,1,0,0,0), 1,0,0,0, 0,0)); // ADD r4,r3,r3: EX hit
      vt.push_back(vc(st(1,1,3,3,1,1,4,1,0,0,0), 1,0,0,0, 1,0)); // MEM hit
      vt.push_back(vc(st(1,1,3,3,1,1,4,1,0,0,0), 0,0,0,0, 2,0)); // WB: write-through
      vt.push_back(vc(st(1,0,4,4,1,1,0,0,0,0,0), 0,0,0,0, 2,0)); // invalid ID never stalls
      vt.push_back(vc(st(1,1,0,0,0,0,5,1,1,0,0), 0,0,0,0, 2,0)); // LD r5
      vt.push_back(vc(st(1,1,5,0,1,0,6,1,0,1,0), 0,1,0,0, 2,0)); // brc over hazard
      vt.push_back(vc(st(1,1,5,0,1,0,6,1,0,0,0), 1,0,0,0, 2,1)); // LD r5 in MEM
      vt.push_back(vc(st(1,1,5,0,1,0,6,1,0,0,1), 0,1,0,0, 3,1)); // jump
      vt.push_back(vc(st(1,0,0,0,0,0,0,0,0,0,1), 0,1,0,0, 3,2)); // consecutive flush
      vt.push_back(vc(st(1,0,0,0,0,0,0,0,0,0,0), 0,0,0,0, 3,3)); // idle
`endif

      drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge CLK);
      do_reset();

      // Reset state
      chk("reset.stall", 32'(bus.stall), 32'd0);
      chk("reset.flush", 32'(bus.flush), 32'd0);
      chk("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("reset.flush_cnt", 32'(bus.flush_cnt), 32'd0);

      // Table-driven vectors
      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].in);
         #2;
         chk($sformatf("vec%0d.stall", i), 32'(bus.stall), 32'(vt[i].stall));
         chk($sformatf("vec%0d.flush", i), 32'(bus.flush), 32'(vt[i].flush));
         chk($sformatf("vec%0d.fwd_a", i), 32'(bus.fwd_a), 32'(vt[i].fa));
         chk($sformatf("vec%0d.fwd_b", i), 32'(bus.fwd_b), 32'(vt[i].fb));
         chk($sformatf("vec%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(vt[i].scnt));
         chk($sformatf("vec%0d.flush_cnt", i), 32'(bus.flush_cnt), 32'(vt[i].fcnt));
         @(posedge CLK);
         @(negedge CLK);
      end

      // Reset asserted during a stall cycle aborts it
      do_reset();
      drive(st(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0));          // LD r3
      @(posedge CLK); @(negedge CLK);
      drive(st(1, 1, 3, 1, 1, 0, 4, 1, 0, 0, 0));          // consumer of r3
      #2;
      chk("rststall.pre_stall", 32'(bus.stall), 32'd1);
      @(posedge CLK); @(negedge CLK);
      chk("rststall.cnt_before", 32'(bus.stall_cnt), 32'd1);
      drive(st(0, 1, 3, 1, 1, 0, 4, 1, 0, 1, 0));          // reset + brc
      #2;
      chk("rststall.in_reset_stall", 32'(bus.stall), 32'd0);
      chk("rststall.in_reset_flush", 32'(bus.flush), 32'd0);
      @(posedge CLK); @(negedge CLK);
      drive(st(1, 1, 3, 1, 1, 0, 4, 1, 0, 0, 0));
      #2;
      chk("rststall.post_stall", 32'(bus.stall), 32'd0);
      chk("rststall.post_flush", 32'(bus.flush), 32'd0);
      chk("rststall.post_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      chk("rststall.post_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      @(posedge CLK); @(negedge CLK);

      // Random traffic against the model (first cycle resets both)
      run_random(3000);

      // Flush counter saturation
      do_reset();
      drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      repeat (65534) @(posedge CLK);
      @(negedge CLK);
      chk("sat.flush_cnt_65534", 32'(bus.flush_cnt), 32'hFFFE);
      @(posedge CLK); @(negedge CLK);
      chk("sat.flush_cnt_65535", 32'(bus.flush_cnt), 32'hFFFF);
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("sat.flush_cnt_held", 32'(bus.flush_cnt), 32'hFFFF);
      chk("sat.flush_still", 32'(bus.flush), 32'd1);
      chk("sat.stall_cnt", 32'(bus.stall_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
